// File: rtl/sw_debounce_multi.sv
// Multi-channel switch debouncer: 2-FF synchroniser, shared sample prescaler,
// N-sample stability filter, and press/release/long-press pulses per channel.
module sw_debounce_multi #(
    parameter bit P_SIM      = 1'b0,
    parameter int P_CH       = 8,
    parameter bit P_INIT_VAL = 1'b0,
    parameter int P_SAMP_CNT = 10000,
    parameter int P_STABLE_N = 3,
    parameter int P_LONG_N   = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [P_CH-1:0] SW_I,
    output logic [P_CH-1:0] SW_O,
    output logic [P_CH-1:0] SW_PRESS,
    output logic [P_CH-1:0] SW_REL,
    output logic [P_CH-1:0] SW_LONG,
    output logic            SAMP_TICK
);

    localparam int            PER       = P_SIM ? 2 : P_SAMP_CNT;
    localparam int            STAB_W    = $clog2(P_STABLE_N);
    localparam logic [15:0]   PER_LAST  = 16'(PER - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(P_STABLE_N - 1);
    localparam logic [15:0]   LONG_N    = 16'(P_LONG_N);
    localparam bit            LONG_EN   = (P_LONG_N != 0);

    logic [P_CH-1:0]   r_sync1;
    logic [P_CH-1:0]   r_sync2;
    logic [15:0]       r_pre;
    logic              r_tick;
    logic              w_pre_last;
    logic [P_CH-1:0]   r_sw_o;
    logic [P_CH-1:0]   r_press;
    logic [P_CH-1:0]   r_rel;
    logic [P_CH-1:0]   r_long_p;
    logic [STAB_W-1:0] r_stab [P_CH];
    logic [15:0]       r_long [P_CH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= {P_CH{P_INIT_VAL}};
            r_sync2 <= {P_CH{P_INIT_VAL}};
        end else begin
            r_sync1 <= SW_I;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pre_last = (r_pre == PER_LAST);

    // Tick is registered so it lands exactly PER clocks after reset release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pre  <= w_pre_last ? '0 : r_pre + 16'd1;
            r_tick <= w_pre_last;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sw_o  <= {P_CH{P_INIT_VAL}};
            r_press <= '0;
            r_rel   <= '0;
            for (int i = 0; i < P_CH; i++) begin
                r_stab[i] <= '0;
            end
        end else begin
            r_press <= '0;
            r_rel   <= '0;
            for (int i = 0; i < P_CH; i++) begin
                if (r_tick) begin
                    if (r_sync2[i] != r_sw_o[i]) begin
                        if (r_stab[i] == STAB_LAST) begin
                            r_sw_o[i] <= r_sync2[i];
                            r_stab[i] <= '0;
                            if (r_sync2[i] != P_INIT_VAL) begin
                                r_press[i] <= 1'b1;
                            end else begin
                                r_rel[i] <= 1'b1;
                            end
                        end else begin
                            r_stab[i] <= r_stab[i] + STAB_W'(1);
                        end
                    end else begin
                        r_stab[i] <= '0;
                    end
                end
            end
        end
    end

    // Long counter saturates at LONG_N so the pulse fires once per hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_long_p <= '0;
            for (int i = 0; i < P_CH; i++) begin
                r_long[i] <= '0;
            end
        end else begin
            r_long_p <= '0;
            for (int i = 0; i < P_CH; i++) begin
                if (!LONG_EN || (r_sw_o[i] == P_INIT_VAL)) begin
                    r_long[i] <= '0;
                end else if (r_tick && (r_long[i] != LONG_N)) begin
                    r_long[i] <= r_long[i] + 16'd1;
                    if (r_long[i] == LONG_N - 16'd1) begin
                        r_long_p[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign SW_O      = r_sw_o;
    assign SW_PRESS  = r_press;
    assign SW_REL    = r_rel;
    assign SW_LONG   = r_long_p;
    assign SAMP_TICK = r_tick;

endmodule

// File: tb/tb_sw_debounce_multi.sv
// Bench for sw_debounce_multi: directed scenarios plus random toggling, every
// cycle compared against a sample-level reference model of the debounce rules.
module tb_sw_debounce_multi;

    localparam int CH  = 4;
    localparam int PER = 4;
    localparam int NST = 3;
    localparam int LN  = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic [CH-1:0] SW_I;
    logic [CH-1:0] SW_O;
    logic [CH-1:0] SW_PRESS;
    logic [CH-1:0] SW_REL;
    logic [CH-1:0] SW_LONG;
    logic          SAMP_TICK;

    sw_debounce_multi #(
        .P_SIM      (1'b0),
        .P_CH       (CH),
        .P_INIT_VAL (1'b0),
        .P_SAMP_CNT (PER),
        .P_STABLE_N (NST),
        .P_LONG_N   (LN)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_I      (SW_I),
        .SW_O      (SW_O),
        .SW_PRESS  (SW_PRESS),
        .SW_REL    (SW_REL),
        .SW_LONG   (SW_LONG),
        .SAMP_TICK (SAMP_TICK)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state: cycle index since reset release, input history,
    // debounced level, differing-sample count and long-press sample count.
    int            cyc;
    logic [CH-1:0] hist [0:8191];
    logic [CH-1:0] m_lvl, m_press, m_rel, m_long;
    logic          m_tick;
    int            m_diff [CH];
    int            m_lc   [CH];

    int            first_tick;
    int            cnt_press [CH];
    int            cnt_rel   [CH];
    int            cnt_long  [CH];
    int            last_press_cyc [CH];
    int            last_long_cyc  [CH];
    logic [CH-1:0] obs_press, obs_swo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [CH-1:0] synced(input int k);
        return (k < 0) ? '0 : hist[k];
    endfunction

    task automatic model_reset();
        cyc     = 0;
        m_lvl   = '0;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        m_tick  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_diff[i] = 0;
            m_lc[i]   = 0;
        end
    endtask

    // Advance over the clock edge that ends cycle 'cyc'.
    task automatic model_advance();
        logic          tick_now;
        logic [CH-1:0] s;
        logic          old;
        tick_now = (cyc % PER == 0) && (cyc > 0);
        s        = synced(cyc - 2);
        m_press  = '0;
        m_rel    = '0;
        m_long   = '0;
        for (int i = 0; i < CH; i++) begin
            old = m_lvl[i];
            if (!old) m_lc[i] = 0;
            if (tick_now) begin
                if (s[i] != old) begin
                    if (m_diff[i] == NST - 1) begin
                        m_lvl[i]  = s[i];
                        m_diff[i] = 0;
                        if (s[i]) m_press[i] = 1'b1;
                        else      m_rel[i]   = 1'b1;
                    end else begin
                        m_diff[i]++;
                    end
                end else begin
                    m_diff[i] = 0;
                end
                if (old && m_lc[i] < LN) begin
                    m_lc[i]++;
                    if (m_lc[i] == LN) m_long[i] = 1'b1;
                end
            end
        end
        cyc++;
        m_tick = (cyc % PER == 0) && (cyc > 0);
    endtask

    // Drive one cycle of input (called just after a rising edge).
    task automatic step(input logic [CH-1:0] v);
        SW_I      = v;
        hist[cyc] = v;
        @(negedge CLK);
        check("sw_o",  32'(SW_O),      32'(m_lvl));
        check("press", 32'(SW_PRESS),  32'(m_press));
        check("rel",   32'(SW_REL),    32'(m_rel));
        check("long",  32'(SW_LONG),   32'(m_long));
        check("tick",  32'(SAMP_TICK), 32'(m_tick));
        obs_press = SW_PRESS;
        obs_swo   = SW_O;
        for (int i = 0; i < CH; i++) begin
            if (SW_PRESS[i]) begin cnt_press[i]++; last_press_cyc[i] = cyc; end
            if (SW_REL[i])   cnt_rel[i]++;
            if (SW_LONG[i])  begin cnt_long[i]++;  last_long_cyc[i]  = cyc; end
        end
        if (SAMP_TICK && first_tick < 0) first_tick = cyc;
        @(posedge CLK);
        #1;
        model_advance();
    endtask

    task automatic hold_reset(input string tag, input int n);
        RST = 1'b1;
        #1;
        check({tag, "_sw_o"},  32'(SW_O),      32'h0);
        check({tag, "_rel"},   32'(SW_REL),    32'h0);
        check({tag, "_press"}, 32'(SW_PRESS),  32'h0);
        check({tag, "_tick"},  32'(SAMP_TICK), 32'h0);
        repeat (n) @(posedge CLK);
        #1;
        check({tag, "_held_sw_o"}, 32'(SW_O),   32'h0);
        check({tag, "_held_rel"},  32'(SW_REL), 32'h0);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [CH-1:0] cur;
        int            s0, lat, p0, r0, l0, bl;
        logic          got;

        RST        = 1'b1;
        SW_I       = '0;
        first_tick = -1;
        for (int i = 0; i < CH; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
            last_press_cyc[i] = 0; last_long_cyc[i] = 0;
        end
        model_reset();
        @(posedge CLK);
        #1;
        hold_reset("por", 3);

        // 1. idle after reset
        repeat (12) step('0);
        check("first_tick_cycle", 32'(first_tick), 32'd4);

        // 2. channel 0 step
        cur = 4'h1;
        s0  = cyc;
        for (int k = 0; k < 30 && cnt_press[0] == 0; k++) step(cur);
        check("press0_seen", 32'(cnt_press[0]), 32'd1);
        lat = last_press_cyc[0] - s0;
        check("press0_latency_in_range", 32'(lat >= 11 && lat <= 15), 32'd1);
        check("others_idle", 32'(obs_swo[3:1]), 32'h0);

        // 3. short glitches on channel 1
        repeat (10) begin
            repeat (6)  step(cur | 4'h2);
            repeat (10) step(cur);
        end
        check("glitch_no_press", 32'(cnt_press[1]), 32'd0);
        check("glitch_no_rel",   32'(cnt_rel[1]),   32'd0);
        check("glitch_sw_o",     32'(obs_swo[1]),   32'd0);

        // 4. long hold on channel 2, then a short hold
        p0 = cnt_press[2]; l0 = cnt_long[2]; r0 = cnt_rel[2];
        repeat (40) step(cur | 4'h4);
        check("ch2_press_once", 32'(cnt_press[2] - p0), 32'd1);
        check("ch2_long_once",  32'(cnt_long[2] - l0),  32'd1);
        check("ch2_long_delay", 32'(last_long_cyc[2] - last_press_cyc[2]), 32'(LN * PER));
        repeat (20) step(cur);
        check("ch2_rel_once", 32'(cnt_rel[2] - r0), 32'd1);
        p0 = cnt_press[2]; l0 = cnt_long[2]; r0 = cnt_rel[2];
        repeat (14) step(cur | 4'h4);
        repeat (20) step(cur);
        check("ch2_short_press", 32'(cnt_press[2] - p0), 32'd1);
        check("ch2_short_rel",   32'(cnt_rel[2] - r0),   32'd1);
        check("ch2_short_nolong", 32'(cnt_long[2] - l0), 32'd0);

        // 5. all channels together
        cur = '0;
        repeat (20) step(cur);
        cur = 4'hF;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step(cur);
            if (obs_press != '0) got = 1'b1;
        end
        check("all_press_same_cycle", 32'(obs_press), 32'hF);
        step(cur);
        check("all_sw_o", 32'(obs_swo), 32'hF);

        // 6. reset mid long-count, channel 0 still held
        repeat (6) step(cur);
        r0   = cnt_rel[0];
        p0   = cnt_press[0];
        cur  = 4'h1;
        SW_I = cur;
        hold_reset("mid", 3);
        bl = 0;
        for (int k = 0; k < 30 && cnt_press[0] == p0; k++) begin
            step(cur);
            bl++;
        end
        check("rst_press0_again", 32'(cnt_press[0] - p0), 32'd1);
        lat = last_press_cyc[0];
        check("rst_press0_latency", 32'(lat >= 11 && lat <= 15), 32'd1);
        check("rst_no_rel", 32'(cnt_rel[0] - r0), 32'd0);

        // random toggling
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 9) == 0) cur[i] = ~cur[i];
            end
            step(cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
